// File: rtl/nn_act_pkg.sv
// rtl/nn_act_pkg.sv - shared fp16 activation constants and sequencer state type
package nn_act_pkg;
  localparam logic [15:0] FP16_FOUR   = 16'h4400;
  localparam logic [15:0] FP16_ZERO   = 16'h0000;
  localparam int          ACT_LATENCY = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} seq_state_e;
endpackage

// File: rtl/fp16_sat_clamp.sv
// rtl/fp16_sat_clamp.sv - clamps positive fp16 values at +4.0 (including +inf and NaN)
module fp16_sat_clamp
  import nn_act_pkg::*;
(
  input  logic [15:0] val,
  input  logic        en,
  output logic [15:0] out_val,
  output logic        hit
);
  always_comb begin
    hit     = en && !val[15] && (val[14:0] >= FP16_FOUR[14:0]);
    out_val = hit ? FP16_FOUR : val;
  end
endmodule

// File: rtl/relu_layer_sequencer.sv
// rtl/relu_layer_sequencer.sv - streams one layer through an external registered activation unit
module relu_layer_sequencer
  import nn_act_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_neurons,
  input  logic              sat_enable,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_rd_data,
  output logic [15:0]       act_in,
  input  logic [15:0]       act_out,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [15:0]       dst_wr_data,
  output logic [CNT_W-1:0]  zero_count,
  output logic [CNT_W-1:0]  sat_count
);
  localparam int PIPE_W = 2 + ACT_LATENCY;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  seq_state_e        state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic              sat_en_q, sat_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d, wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  n_q, n_d, zero_q, zero_d, sat_q, sat_d;
  logic [PIPE_W-1:0] valid_q, valid_d;
  logic [15:0]       wr_data_q, wr_data_d, clamp_val;
  logic              clamp_hit;

  assign act_in = src_rd_data;

  fp16_sat_clamp u_clamp (
    .val     (act_out),
    .en      (sat_en_q),
    .out_val (clamp_val),
    .hit     (clamp_hit)
  );

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = rd_en_q;
    rd_idx_d  = rd_idx_q;
    n_d       = n_q;
    sat_en_d  = sat_en_q;
    zero_d    = zero_q;
    sat_d     = sat_q;
    wr_idx_d  = wr_idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = num_neurons;
          sat_en_d = sat_enable;
          zero_d   = '0;
          sat_d    = '0;
          rd_idx_d = '0;
          wr_idx_d = '0;
          if (num_neurons != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        // Hold the final address rather than wrapping when N fills the buffer.
        if (CNT_W'(rd_idx_q) == n_q - CNT_ONE) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + ADDR_ONE;
        end
      end
      DRAIN: begin
        if (valid_q == '0) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d = {valid_q[PIPE_W-2:0], rd_en_d};
    if (valid_q[1] && act_in[15]) zero_d = zero_q + CNT_ONE;
    wr_en_d = valid_q[PIPE_W-1];
    if (valid_q[PIPE_W-1]) begin
      wr_addr_d = wr_idx_q;
      wr_idx_d  = wr_idx_q + ADDR_ONE;
      wr_data_d = clamp_val;
      if (clamp_hit) sat_d = sat_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      n_q       <= '0;
      sat_en_q  <= 1'b0;
      zero_q    <= '0;
      sat_q     <= '0;
      valid_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= FP16_ZERO;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_idx_q  <= rd_idx_d;
      n_q       <= n_d;
      sat_en_q  <= sat_en_d;
      zero_q    <= zero_d;
      sat_q     <= sat_d;
      valid_q   <= valid_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign src_rd_en   = rd_en_q;
  assign src_addr    = rd_idx_q;
  assign dst_wr_en   = wr_en_q;
  assign dst_addr    = wr_addr_q;
  assign dst_wr_data = wr_data_q;
  assign zero_count  = zero_q;
  assign sat_count   = sat_q;
endmodule

// File: tb/tb_relu_layer_sequencer.sv
// tb/tb_relu_layer_sequencer.sv - self-checking bench for relu_layer_sequencer
module tb_relu_layer_sequencer;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 9;

  logic              clk = 1'b0, rst = 1'b0, start = 1'b0, sat_enable = 1'b0;
  logic [CNT_W-1:0]  num_neurons = '0;
  logic              busy, done, src_rd_en, dst_wr_en;
  logic [ADDR_W-1:0] src_addr, dst_addr;
  logic [15:0]       src_rd_data = '0, act_out = '0, act_in, dst_wr_data;
  logic [CNT_W-1:0]  zero_count, sat_count;

  int checks = 0, errors = 0;
  logic [15:0] src_mem [256];
  logic [15:0] dst_mem [256];

  // Reference model state: one accepted layer, timed relative to its start edge.
  bit          running = 0, m_sat = 0;
  int          cyc = 0, c0 = 0, m_n = 0, done_c = 0, c = 0;
  int          exp_zero = 0, exp_sat = 0;
  logic [15:0] exp_out [256];
  int          rd_seen = 0, wr_seen = 0, busy_seen = 0, done_at = -1;

  always #5 clk = ~clk;

  relu_layer_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .sat_enable(sat_enable), .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
    .act_in(act_in), .act_out(act_out), .dst_wr_en(dst_wr_en),
    .dst_addr(dst_addr), .dst_wr_data(dst_wr_data),
    .zero_count(zero_count), .sat_count(sat_count)
  );

  // Source buffer with one cycle read latency and a registered ReLU unit.
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= src_mem[src_addr];
    act_out <= act_in[15] ? 16'h0000 : act_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] layer_out(input logic [15:0] x, input bit sat);
    logic [15:0] r;
    r = x[15] ? 16'h0000 : x;
    if (sat && r >= 16'h4400) r = 16'h4400;
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        running  = 0;
        exp_zero = 0;
        exp_sat  = 0;
      end else if (start && (!running || (cyc - c0 + 1) > done_c)) begin
        running = 1;
        c0      = cyc + 1;
        m_n     = int'(num_neurons);
        m_sat   = sat_enable;
        done_c  = (m_n == 0) ? 1 : m_n + 4;
        exp_zero = 0;
        exp_sat  = 0;
        for (int i = 0; i < m_n; i++) begin
          exp_out[i] = layer_out(src_mem[i], m_sat);
          if (src_mem[i][15]) exp_zero++;
          if (m_sat && !src_mem[i][15] && src_mem[i] >= 16'h4400) exp_sat++;
        end
        for (int i = 0; i < 256; i++) dst_mem[i] = 16'hDEAD;
        rd_seen = 0; wr_seen = 0; busy_seen = 0; done_at = -1;
      end
      cyc++;

      @(negedge clk);
      if (!rst) begin
        c = cyc - c0 + 1;
        if (src_rd_en) rd_seen++;
        if (busy) busy_seen++;
        if (done) done_at = c;
        if (dst_wr_en) begin
          dst_mem[dst_addr] = dst_wr_data;
          wr_seen++;
        end
        chk("src_rd_en", 32'(src_rd_en), 32'(running && m_n > 0 && c >= 1 && c <= m_n));
        chk("dst_wr_en", 32'(dst_wr_en), 32'(running && m_n > 0 && c >= 4 && c <= m_n + 3));
        chk("busy", 32'(busy), 32'(running && m_n > 0 && c >= 1 && c <= m_n + 3));
        chk("done", 32'(done), 32'(running && c == done_c));
        if (running && m_n > 0 && c >= 1 && c <= m_n)
          chk("src_addr", 32'(src_addr), 32'((c - 1) % 256));
        if (running && m_n > 0 && c >= 4 && c <= m_n + 3) begin
          chk("dst_addr", 32'(dst_addr), 32'((c - 4) % 256));
          chk("dst_wr_data", 32'(dst_wr_data), 32'(exp_out[c - 4]));
        end
        if (!running || c >= done_c) begin
          chk("zero_count", 32'(zero_count), 32'(exp_zero));
          chk("sat_count", 32'(sat_count), 32'(exp_sat));
        end
      end
    end
  end

  task automatic launch(input int n, input bit sat);
    @(negedge clk);
    start       = 1'b1;
    num_neurons = CNT_W'(n);
    sat_enable  = sat;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer(input int n, input bit sat);
    launch(n, sat);
    repeat (n + 5) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rd_en"}, 32'(src_rd_en), 0);
    chk({tag, "_src_addr"}, 32'(src_addr), 0);
    chk({tag, "_wr_en"}, 32'(dst_wr_en), 0);
    chk({tag, "_dst_addr"}, 32'(dst_addr), 0);
    chk({tag, "_wr_data"}, 32'(dst_wr_data), 0);
    chk({tag, "_zero"}, 32'(zero_count), 0);
    chk({tag, "_sat"}, 32'(sat_count), 0);
  endtask

  initial begin
    int wr_snap;
    logic [7:0] b;
    #1 rst = 1'b1;
    #1 chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Mixed signs, exact +4.0 and -0.0 with the clamp on.
    src_mem[0] = 16'h3C00; src_mem[1] = 16'hBC00; src_mem[2] = 16'h4400; src_mem[3] = 16'h8000;
    run_layer(4, 1'b1);
    chk("s1_w0", 32'(dst_mem[0]), 32'h3C00);
    chk("s1_w1", 32'(dst_mem[1]), 32'h0000);
    chk("s1_w2", 32'(dst_mem[2]), 32'h4400);
    chk("s1_w3", 32'(dst_mem[3]), 32'h0000);
    chk("s1_zero", 32'(zero_count), 2);
    chk("s1_sat", 32'(sat_count), 1);
    chk("s1_done_cycle", 32'(done_at), 8);

    src_mem[0] = 16'h4800; src_mem[1] = 16'h7C00;
    run_layer(2, 1'b0);
    chk("s2_w0", 32'(dst_mem[0]), 32'h4800);
    chk("s2_w1", 32'(dst_mem[1]), 32'h7C00);
    chk("s2_sat", 32'(sat_count), 0);

    run_layer(2, 1'b1);
    chk("s3_w0", 32'(dst_mem[0]), 32'h4400);
    chk("s3_w1", 32'(dst_mem[1]), 32'h4400);
    chk("s3_sat", 32'(sat_count), 2);

    run_layer(0, 1'b1);
    chk("n0_done_cycle", 32'(done_at), 1);
    chk("n0_reads", 32'(rd_seen), 0);
    chk("n0_writes", 32'(wr_seen), 0);
    chk("n0_busy", 32'(busy_seen), 0);

    // Full buffer; a start pulse in cycle 100 must be ignored.
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      src_mem[i] = {b, b};
    end
    launch(256, 1'b1);
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (165) @(negedge clk);
    chk("full_done_cycle", 32'(done_at), 260);
    chk("full_reads", 32'(rd_seen), 256);
    chk("full_writes", 32'(wr_seen), 256);
    chk("full_busy", 32'(busy_seen), 259);
    chk("full_zero", 32'(zero_count), 128);
    chk("full_sat", 32'(sat_count), 60);
    chk("full_w255", 32'(dst_mem[255]), 32'h0000);
    chk("full_w67", 32'(dst_mem[67]), 32'h4343);

    // Abort an N=10 layer in cycle 5, then run cleanly.
    launch(10, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_outputs_zero("abort");
    wr_snap = wr_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_writes", 32'(wr_seen), 32'(wr_snap));

    src_mem[0] = 16'h3C00; src_mem[1] = 16'h4000; src_mem[2] = 16'hC000;
    run_layer(3, 1'b0);
    chk("rerun_w0", 32'(dst_mem[0]), 32'h3C00);
    chk("rerun_w1", 32'(dst_mem[1]), 32'h4000);
    chk("rerun_w2", 32'(dst_mem[2]), 32'h0000);
    chk("rerun_zero", 32'(zero_count), 1);
    chk("rerun_done_cycle", 32'(done_at), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_layer_sequencer.md
# relu_layer_sequencer

Sequences one layer's worth of fp16 neuron pre-activations through the registered ReLU activation unit. On `start`, it streams values from a source buffer into the unit and applies an optional saturation clamp at +4.0. It writes the results to a destination buffer and reports zero/saturation statistics. It sits between the layer accumulator buffer and the next layer's input buffer.

## Interface
Parameters:
- `ADDR_W`, 8: buffer address width; layer size is up to 2^ADDR_W neurons.
- `CNT_W`, `ADDR_W+1`: width of the length input and the statistic counters.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to run a layer; sampled only in IDLE.
- `num_neurons`  in  CNT_W  layer length; sampled with `start`.
- `sat_enable`  in  1  clamp enable; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of the layer.
- `src_rd_en`  out  1  source buffer read strobe.
- `src_addr`  out  ADDR_W  source read address.
- `src_rd_data`  in  16  source data, valid 1 cycle after `src_rd_en`.
- `act_in`  out  16  drives the activation unit; equals `src_rd_data`.
- `act_out`  in  16  activation unit result, registered, 1-cycle latency.
- `dst_wr_en`, `dst_addr` [ADDR_W], `dst_wr_data` [16]  out  destination write port.
- `zero_count`  out  CNT_W  number of inputs with sign bit set in the last layer.
- `sat_count`  out  CNT_W  number of outputs clamped to +4.0 in the last layer.

## Operation
- FSM states:
  - IDLE: `start`=1 with `num_neurons`>0 goes to RUN. `start`=1 with `num_neurons`=0 goes to FIN. Otherwise stay.
  - RUN: issues one read per cycle at addresses 0..N-1. Goes to DRAIN after read N-1.
  - DRAIN: waits until the last write has issued, then goes to FIN.
  - FIN: asserts `done` for one cycle, then goes to IDLE.
- On `start` acceptance, the statistic counters clear to 0.
- `start` is ignored outside IDLE; it is never queued.
- The pipeline valid tracking is a 3-bit shift register: read, data, act.
- `zero_count` increments when the data stage is valid and `act_in[15]`=1. This includes -0.0 (0x8000).
- Clamp, applied at the act stage, with v = `act_out`:
  - If `sat_enable` and v[15]=0 and v[14:0] >= 15'h4400, the output is 16'h4400 and `sat_count` increments.
  - The condition includes +4.0 exactly, +inf and NaN.
  - Otherwise the output is v, unchanged.
- The write address counter runs independently of the read counter. It starts at 0 and increments on each write.
- Counters are CNT_W wide. N=2^ADDR_W is legal; the address wraps only after the final element.
- Statistics hold their values after `done` until the next accepted `start`.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `src_rd_en`=0, `src_addr`=0, `dst_wr_en`=0, `dst_addr`=0, `dst_wr_data`=0, `zero_count`=0, `sat_count`=0.
- Reset mid-layer aborts immediately. No further reads or writes occur, and statistics clear.
- Cycle numbering: `start` is sampled at edge 0.
  - Element i is read in cycle 1+i.
  - It appears on `act_in` in cycle 2+i.
  - It returns on `act_out` in cycle 3+i.
  - It is written, registered, in cycle 4+i.
- For N>0, `busy` is high in cycles 1..N+3.
- `done` pulses in cycle N+4, with `busy` low. Total latency from `start` to `done` is N+4 cycles.
- For N=0, `busy`=0, `done` pulses in cycle 1, and there are no reads or writes.
- Throughput is one element per clock. There is no backpressure: the destination must accept every write.
- A new `start` is accepted in cycle N+5 at the earliest, because `start` is only sampled in IDLE.

## Structure
- Shared package `nn_act_pkg` holds:
  - `FP16_FOUR` = 16'h4400
  - `FP16_ZERO` = 16'h0000
  - `ACT_LATENCY` = 1
  - the FSM state enum {IDLE, RUN, DRAIN, FIN}
- One sub-module, `fp16_sat_clamp`: combinational. Inputs are the value and the enable; outputs are the clamped value and a hit flag.
- The activation unit stays external. This keeps the sequencer reusable with alternative activations of equal latency.

## Test plan
- Directed scenarios:
  - Reset, then N=4 with source {0x3C00, 0xBC00, 0x4400, 0x8000} and `sat_enable`=1.
    - Required writes, in cycles 4..7: {0x3C00, 0x0000, 0x4400, 0x0000}.
    - Required statistics: `zero_count`=2, `sat_count`=1, `done` pulse in cycle 8.
  - `sat_enable`=0 with source {0x4800, 0x7C00}: writes {0x4800, 0x7C00}, `sat_count`=0.
  - Same source with `sat_enable`=1: writes {0x4400, 0x4400}, `sat_count`=2.
  - N=0: `done` pulses in cycle 1, no `src_rd_en`, no `dst_wr_en`, `busy` never high.
  - N=256 with `ADDR_W`=8:
    - `src_addr` runs 0..255 contiguously and `dst_addr` runs 0..255.
    - `done` pulses in cycle 260.
    - `start` pulsed in cycle 100 is ignored, with no restart.
  - Assert `rst` in cycle 5 of an N=10 run:
    - All outputs go to 0 asynchronously and no writes follow.
    - A new `start` after release runs cleanly from address 0.
